// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 datapath types and widths
package lc3_pkg;

  localparam int WORD_W = 16;

  typedef enum logic {
    ADDR1_PC    = 1'b0,
    ADDR1_BASER = 1'b1
  } addr1_sel_e;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'b00,
    ADDR2_OFF6  = 2'b01,
    ADDR2_OFF9  = 2'b10,
    ADDR2_OFF11 = 2'b11
  } addr2_sel_e;

endpackage

// File: rtl/addr_gen_stage_if.sv
// rtl/addr_gen_stage_if.sv - upstream/downstream bus of the address-generation stage
interface addr_gen_stage_if;
  import lc3_pkg::*;

  logic              InValid;
  logic              InReady;
  logic [WORD_W-1:0] IR;
  logic [WORD_W-1:0] PC;
  logic [WORD_W-1:0] BaseR;
  addr1_sel_e        Addr1Sel;
  addr2_sel_e        Addr2Sel;
  logic              BrCheck;
  logic              CCLoad;
  logic [WORD_W-1:0] CCValue;
  logic              OutValid;
  logic              OutReady;
  logic [WORD_W-1:0] Addr;
  logic              Taken;

  modport master (
    output InValid, IR, PC, BaseR, Addr1Sel, Addr2Sel, BrCheck, CCLoad, CCValue, OutReady,
    input  InReady, OutValid, Addr, Taken
  );

  modport slave (
    input  InValid, IR, PC, BaseR, Addr1Sel, Addr2Sel, BrCheck, CCLoad, CCValue, OutReady,
    output InReady, OutValid, Addr, Taken
  );

endinterface

// File: rtl/cc_reg.sv
// rtl/cc_reg.sv - NZP condition-code register, loaded from the value written to DR
module cc_reg
  import lc3_pkg::*;
#(
  parameter logic [2:0] NZP_RESET = 3'b010
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              CCLoad,
  input  logic [WORD_W-1:0] CCValue,
  output logic [2:0]        NZP
);

  logic is_neg;
  logic is_zero;

  assign is_neg  = CCValue[WORD_W-1];
  assign is_zero = (CCValue == '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      NZP <= NZP_RESET;
    end else if (CCLoad) begin
      NZP <= {is_neg, is_zero, ~is_neg & ~is_zero};
    end
  end

endmodule

// File: rtl/addr_gen_stage.sv
// rtl/addr_gen_stage.sv - base+offset address generation and BR evaluation, 2-stage valid/ready pipe
module addr_gen_stage
  import lc3_pkg::*;
#(
  parameter logic [2:0] NZP_RESET = 3'b010
) (
  input logic              Clk,
  input logic              Reset_n,
  addr_gen_stage_if.slave  bus
);

  logic [2:0]        nzp;
  logic              adv1;
  logic              adv2;
  logic              accept;
  logic [WORD_W-1:0] base_sel;
  logic [WORD_W-1:0] off_sel;
  logic              taken_in;
  logic              s1V;
  logic [WORD_W-1:0] s1_base;
  logic [WORD_W-1:0] s1_off;
  logic              s1_taken;
  logic              s2V;
  logic [WORD_W-1:0] addr_q;
  logic              taken_q;
  logic              unused_ir;

  cc_reg #(.NZP_RESET(NZP_RESET)) u_cc_reg (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .CCLoad  (bus.CCLoad),
    .CCValue (bus.CCValue),
    .NZP     (nzp)
  );

  assign unused_ir = ^bus.IR[15:12];

  // Stage 2 frees when empty or popping; stage 1 frees when empty or stage 2 frees.
  assign adv2   = ~s2V | bus.OutReady;
  assign adv1   = ~s1V | adv2;
  assign accept = bus.InValid & adv1;

  always_comb begin
    base_sel = (bus.Addr1Sel == ADDR1_BASER) ? bus.BaseR : bus.PC;
    off_sel  = '0;
    case (bus.Addr2Sel)
      ADDR2_OFF6:  off_sel = {{10{bus.IR[5]}},  bus.IR[5:0]};
      ADDR2_OFF9:  off_sel = {{7{bus.IR[8]}},   bus.IR[8:0]};
      ADDR2_OFF11: off_sel = {{5{bus.IR[10]}},  bus.IR[10:0]};
      default:     off_sel = '0;
    endcase
    taken_in = bus.BrCheck & |(bus.IR[11:9] & nzp);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1V      <= 1'b0;
      s1_base  <= '0;
      s1_off   <= '0;
      s1_taken <= 1'b0;
    end else if (adv1) begin
      s1V <= bus.InValid;
      if (accept) begin
        s1_base  <= base_sel;
        s1_off   <= off_sel;
        s1_taken <= taken_in;
      end
    end
  end

  // Carry out of the add is dropped so addresses wrap modulo 2^16.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2V     <= 1'b0;
      addr_q  <= '0;
      taken_q <= 1'b0;
    end else if (adv2) begin
      s2V <= s1V;
      if (s1V) begin
        addr_q  <= s1_base + s1_off;
        taken_q <= s1_taken;
      end
    end
  end

  assign bus.InReady  = adv1;
  assign bus.OutValid = s2V;
  assign bus.Addr     = addr_q;
  assign bus.Taken    = taken_q;

endmodule

// File: tb/tb_addr_gen_stage.sv
// tb/tb_addr_gen_stage.sv - directed self-checking bench for addr_gen_stage
module tb_addr_gen_stage;
  import lc3_pkg::*;

  logic Clk;
  logic Reset_n;
  int   total;
  int   bad;

  addr_gen_stage_if bus ();

  addr_gen_stage #(.NZP_RESET(3'b010)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic set_op(input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] baser,
                        input addr1_sel_e a1, input addr2_sel_e a2, input logic br);
    bus.InValid  = 1'b1;
    bus.IR       = ir;
    bus.PC       = pc;
    bus.BaseR    = baser;
    bus.Addr1Sel = a1;
    bus.Addr2Sel = a2;
    bus.BrCheck  = br;
  endtask

  task automatic test_reset;
    Reset_n      = 1'b0;
    bus.InValid  = 1'b0;
    bus.IR       = '0;
    bus.PC       = '0;
    bus.BaseR    = '0;
    bus.Addr1Sel = ADDR1_PC;
    bus.Addr2Sel = ADDR2_ZERO;
    bus.BrCheck  = 1'b0;
    bus.CCLoad   = 1'b0;
    bus.CCValue  = '0;
    bus.OutReady = 1'b1;
    repeat (2) @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%b want=0", bus.OutValid); end
    total++;
    if (bus.Addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", bus.Addr); end
    total++;
    if (bus.Taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b want=0", bus.Taken); end
    Reset_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.InReady !== 1'b1) begin bad++; $display("FAIL reset_inready got=%b want=1", bus.InReady); end
  endtask

  task automatic test_basic;
    bus.OutReady = 1'b1;
    set_op(16'h01FF, 16'h3000, 16'h0000, ADDR1_PC, ADDR2_OFF9, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    total++;
    if (bus.OutValid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", bus.OutValid); end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b1 || bus.Addr !== 16'h2FFF) begin
      bad++; $display("FAIL basic_addr got=%b/%h want=1/2fff", bus.OutValid, bus.Addr);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    bus.OutReady = 1'b1;
    set_op(16'h001F, 16'h0000, 16'h4000, ADDR1_BASER, ADDR2_OFF6, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    set_op(16'h0020, 16'h0000, 16'h4000, ADDR1_BASER, ADDR2_OFF6, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    total++;
    if (bus.OutValid !== 1'b1 || bus.Addr !== 16'h401F) begin
      bad++; $display("FAIL b2b_first got=%b/%h want=1/401f", bus.OutValid, bus.Addr);
    end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b1 || bus.Addr !== 16'h3FE0) begin
      bad++; $display("FAIL b2b_second got=%b/%h want=1/3fe0", bus.OutValid, bus.Addr);
    end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", bus.OutValid); end
  endtask

  task automatic test_wrap;
    bus.OutReady = 1'b1;
    set_op(16'h0001, 16'hFFFF, 16'h0000, ADDR1_PC, ADDR2_OFF11, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    set_op(16'hFFFF, 16'h0000, 16'h1234, ADDR1_BASER, ADDR2_ZERO, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    total++;
    if (bus.OutValid !== 1'b1 || bus.Addr !== 16'h0000) begin
      bad++; $display("FAIL wrap_addr got=%b/%h want=1/0000", bus.OutValid, bus.Addr);
    end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b1 || bus.Addr !== 16'h1234) begin
      bad++; $display("FAIL zero_offset got=%b/%h want=1/1234", bus.OutValid, bus.Addr);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_backpressure;
    bus.OutReady = 1'b0;
    set_op(16'h0000, 16'h0000, 16'h1111, ADDR1_BASER, ADDR2_ZERO, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    set_op(16'h0000, 16'h0000, 16'h2222, ADDR1_BASER, ADDR2_ZERO, 1'b0);
    #1;
    total++;
    if (bus.InReady !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b want=1", bus.InReady); end
    @(posedge Clk);
    @(negedge Clk);
    set_op(16'h0000, 16'h0000, 16'h3333, ADDR1_BASER, ADDR2_ZERO, 1'b0);
    #1;
    total++;
    if (bus.InReady !== 1'b0 || bus.OutValid !== 1'b1 || bus.Addr !== 16'h1111) begin
      bad++; $display("FAIL bp_full got=%b/%b/%h want=0/1/1111", bus.InReady, bus.OutValid, bus.Addr);
    end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.InReady !== 1'b0 || bus.Addr !== 16'h1111) begin
      bad++; $display("FAIL bp_hold got=%b/%h want=0/1111", bus.InReady, bus.Addr);
    end
    bus.OutReady = 1'b1;
    #1;
    total++;
    if (bus.InReady !== 1'b1) begin bad++; $display("FAIL bp_pop_push got=%b want=1", bus.InReady); end
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    total++;
    if (bus.OutValid !== 1'b1 || bus.Addr !== 16'h2222) begin
      bad++; $display("FAIL bp_second got=%b/%h want=1/2222", bus.OutValid, bus.Addr);
    end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b1 || bus.Addr !== 16'h3333) begin
      bad++; $display("FAIL bp_third got=%b/%h want=1/3333", bus.OutValid, bus.Addr);
    end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", bus.OutValid); end
  endtask

  task automatic test_branch;
    bus.OutReady = 1'b1;
    bus.InValid  = 1'b0;
    bus.CCLoad   = 1'b1;
    bus.CCValue  = 16'h8000;
    @(posedge Clk);
    @(negedge Clk);
    bus.CCLoad = 1'b0;
    set_op(16'h0800, 16'h0000, 16'h0000, ADDR1_PC, ADDR2_ZERO, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    set_op(16'h0600, 16'h0000, 16'h0000, ADDR1_PC, ADDR2_ZERO, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    total++;
    if (bus.OutValid !== 1'b1 || bus.Taken !== 1'b1) begin
      bad++; $display("FAIL br_n got=%b/%b want=1/1", bus.OutValid, bus.Taken);
    end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b1 || bus.Taken !== 1'b0) begin
      bad++; $display("FAIL br_zp got=%b/%b want=1/0", bus.OutValid, bus.Taken);
    end
    set_op(16'h0400, 16'h0000, 16'h0000, ADDR1_PC, ADDR2_ZERO, 1'b1);
    bus.CCLoad  = 1'b1;
    bus.CCValue = 16'h0000;
    @(posedge Clk);
    @(negedge Clk);
    bus.CCLoad = 1'b0;
    set_op(16'h0400, 16'h0000, 16'h0000, ADDR1_PC, ADDR2_ZERO, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    total++;
    if (bus.OutValid !== 1'b1 || bus.Taken !== 1'b0) begin
      bad++; $display("FAIL br_z_old_nzp got=%b/%b want=1/0", bus.OutValid, bus.Taken);
    end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b1 || bus.Taken !== 1'b1) begin
      bad++; $display("FAIL br_z_new_nzp got=%b/%b want=1/1", bus.OutValid, bus.Taken);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset_midflight;
    bus.OutReady = 1'b0;
    set_op(16'h0800, 16'h0000, 16'h5555, ADDR1_BASER, ADDR2_ZERO, 1'b1);
    bus.CCLoad  = 1'b1;
    bus.CCValue = 16'h8000;
    @(posedge Clk);
    @(negedge Clk);
    bus.CCLoad = 1'b0;
    set_op(16'h0800, 16'h0000, 16'h6666, ADDR1_BASER, ADDR2_ZERO, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    total++;
    if (bus.OutValid !== 1'b1 || bus.Addr !== 16'h5555) begin
      bad++; $display("FAIL mid_held got=%b/%h want=1/5555", bus.OutValid, bus.Addr);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    total++;
    if (bus.OutValid !== 1'b0 || bus.Addr !== 16'h0000 || bus.Taken !== 1'b0) begin
      bad++; $display("FAIL mid_async got=%b/%h/%b want=0/0000/0", bus.OutValid, bus.Addr, bus.Taken);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    bus.OutReady = 1'b1;
    set_op(16'h0400, 16'h0000, 16'h0000, ADDR1_PC, ADDR2_ZERO, 1'b1);
    #1;
    total++;
    if (bus.InReady !== 1'b1) begin bad++; $display("FAIL mid_inready got=%b want=1", bus.InReady); end
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    total++;
    if (bus.OutValid !== 1'b0) begin bad++; $display("FAIL mid_flushed got=%b want=0", bus.OutValid); end
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.OutValid !== 1'b1 || bus.Taken !== 1'b1) begin
      bad++; $display("FAIL mid_nzp_reset got=%b/%b want=1/1", bus.OutValid, bus.Taken);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_branch();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
